// File: rtl/ram64_fifo_pkg.sv
// Shared sizes and types for the 64-deep distributed-RAM FIFO controller.
package ram64_fifo_pkg;
  localparam int DEPTH = 64;
  localparam int PTR_W = 6;
  localparam int CNT_W = 7;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/ram64_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for ram64_fifo_ctrl; the FIFO takes the slave modport.
interface ram64_fifo_ctrl_if #(parameter int WIDTH = 8);
  import ram64_fifo_pkg::*;

  logic             WR_EN;
  logic [WIDTH-1:0] DIN;
  logic             FULL;
  logic             ALMOST_FULL;
  logic             WR_ERR;
  logic             RD_EN;
  logic [WIDTH-1:0] DOUT;
  logic             VALID;
  logic             EMPTY;
  logic             RD_ERR;

  modport master (
    output WR_EN, DIN, RD_EN,
    input  FULL, ALMOST_FULL, WR_ERR, DOUT, VALID, EMPTY, RD_ERR
  );

  modport slave (
    input  WR_EN, DIN, RD_EN,
    output FULL, ALMOST_FULL, WR_ERR, DOUT, VALID, EMPTY, RD_ERR
  );
endinterface

// File: rtl/ram64_dp_bank.sv
// WIDTH parallel 64x1 dual-port RAM slices: synchronous write on A, asynchronous reads on A and DPRA.
module ram64_dp_bank
  import ram64_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             WE,
  input  ptr_t             A,
  input  logic [WIDTH-1:0] D,
  input  ptr_t             DPRA,
  output logic [WIDTH-1:0] SPO,
  output logic [WIDTH-1:0] DPO
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic [DEPTH-1:0] bits;

    // Storage is deliberately not reset, matching a distributed RAM primitive.
    always_ff @(posedge C) begin
      if (WE) bits[A] <= D[i];
    end

    assign SPO[i] = bits[A];
    assign DPO[i] = bits[DPRA];
  end

endmodule

// File: rtl/ram64_fifo_ctrl.sv
// 64-deep FIFO controller over a ram64_dp_bank; define RAM64_FIFO_CNT_EN to expose DATA_COUNT.
module ram64_fifo_ctrl
  import ram64_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int AF_THRESH = 60
) (
  input  logic               C,
  input  logic               CLR,
  ram64_fifo_ctrl_if.slave   bus
`ifdef RAM64_FIFO_CNT_EN
  ,
  output logic [CNT_W-1:0]   DATA_COUNT
`endif
);

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  cnt_t             cnt;
  cnt_t             cnt_next;
  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] ram_dpo;

  // A read frees a slot in the same edge, so a full FIFO still accepts a paired write.
  assign rd_acc   = bus.RD_EN & ~bus.EMPTY;
  assign wr_acc   = bus.WR_EN & (~bus.FULL | rd_acc);
  assign cnt_next = cnt + {{(CNT_W-1){1'b0}}, wr_acc} - {{(CNT_W-1){1'b0}}, rd_acc};

  ram64_dp_bank #(.WIDTH(WIDTH)) u_bank (
    .C    (C),
    .WE   (wr_acc),
    .A    (wr_ptr),
    .D    (bus.DIN),
    .DPRA (rd_ptr),
    .SPO  (),
    .DPO  (ram_dpo)
  );

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cnt             <= '0;
      bus.EMPTY       <= 1'b1;
      bus.FULL        <= 1'b0;
      bus.ALMOST_FULL <= 1'b0;
      bus.VALID       <= 1'b0;
      bus.WR_ERR      <= 1'b0;
      bus.RD_ERR      <= 1'b0;
      bus.DOUT        <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ptr_t'(1);
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + ptr_t'(1);
        bus.DOUT <= ram_dpo;
      end
      cnt             <= cnt_next;
      bus.EMPTY       <= (cnt_next == '0);
      bus.FULL        <= (cnt_next == cnt_t'(DEPTH));
      bus.ALMOST_FULL <= (cnt_next >= cnt_t'(AF_THRESH));
      bus.VALID       <= rd_acc;
      bus.WR_ERR      <= bus.WR_EN & bus.FULL & ~rd_acc;
      bus.RD_ERR      <= bus.RD_EN & bus.EMPTY;
    end
  end

`ifdef RAM64_FIFO_CNT_EN
  assign DATA_COUNT = cnt;
`endif

endmodule
